scoot_arena: RTL

Grid-world environment stage that sits directly downstream of the scoot bot controller. It consumes the bot's four motor outputs and tracks the bot position on a toroidal pellet map. It collects pellets and feeds the four neighbour light-sensor bits back to the bot's sensor inputs, closing the simulation loop in synthesizable form. It also keeps score and a step budget so a run has a defined end.

---
 rtl/scoot_arena.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/scoot_arena.sv
// Grid-world environment for the scoot bot. It moves the bot on a toroidal pellet map from
// the bot's motor commands, collects pellets, keeps score and a step budget, and returns
// the four neighbour pellet bits to the bot as light sensors.
module scoot_arena #(
  parameter int unsigned         WIDTH       = 10,
  parameter int unsigned         HEIGHT      = 10,
  parameter logic [HEIGHT-1:0]   ROW_PATTERN = 10'b0010101001,
  parameter int unsigned         START_X     = WIDTH / 2,
  parameter int unsigned         START_Y     = HEIGHT / 2,
  parameter int unsigned         NUM_STEPS   = 50,
  parameter int unsigned         COORD_W     = 4,
  parameter int unsigned         SCORE_W     = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               step_en,
  input  logic               mUp,
  input  logic               mRight,
  input  logic               mDown,
  input  logic               mLeft,
  output logic               lUp,
  output logic               lRight,
  output logic               lDown,
  output logic               lLeft,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [SCORE_W-1:0] score,
  output logic               pickup,
  output logic               busy,
  output logic               done
);

  localparam int unsigned Cells = WIDTH * HEIGHT;
  localparam int unsigned IdxW  = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned StepW = $clog2(NUM_STEPS + 1);

  localparam logic [COORD_W-1:0] XMax      = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] YMax      = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] CoordOne  = COORD_W'(1);
  localparam logic [COORD_W-1:0] StartX    = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] StartY    = COORD_W'(START_Y);
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] ScoreMax  = '1;
  localparam logic [StepW-1:0]   StepOne   = StepW'(1);
  localparam logic [StepW-1:0]   StepLimit = StepW'(NUM_STEPS);

  // Map is column-major: cell (x,y) lives at bit x*HEIGHT+y.
  function automatic logic [Cells-1:0] buildMap();
    logic [Cells-1:0] m;
    m = '0;
    for (int unsigned x = 0; x < WIDTH; x++) begin
      m[x*HEIGHT +: HEIGHT] = ROW_PATTERN;
    end
    return m;
  endfunction

  function automatic logic [IdxW-1:0] cellIdx(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y);
    return IdxW'(x) * IdxW'(HEIGHT) + IdxW'(y);
  endfunction

  function automatic logic [COORD_W-1:0] incWrap(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] vMax);
    return (v == vMax) ? '0 : v + CoordOne;
  endfunction

  function automatic logic [COORD_W-1:0] decWrap(input logic [COORD_W-1:0] v,
                                                 input logic [COORD_W-1:0] vMax);
    return (v == '0) ? vMax : v - CoordOne;
  endfunction

  localparam logic [Cells-1:0] InitMap  = buildMap();
  localparam logic [IdxW-1:0]  StartIdx = cellIdx(StartX, StartY);

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateE;

  stateE               stateQ, stateD;
  logic [Cells-1:0]    mapQ, mapD;
  logic [COORD_W-1:0]  posXQ, posXD, posYQ, posYD;
  logic [SCORE_W-1:0]  scoreQ, scoreD;
  logic [StepW-1:0]    stepCntQ, stepCntD;
  logic                pickupQ, pickupD;

  logic [COORD_W-1:0]  nextX, nextY;
  logic [IdxW-1:0]     moveIdx;

  // Target cell of a move; opposing commands on an axis cancel.
  always_comb begin
    nextX = posXQ;
    nextY = posYQ;
    if (mRight && !mLeft) begin
      nextX = incWrap(posXQ, XMax);
    end else if (mLeft && !mRight) begin
      nextX = decWrap(posXQ, XMax);
    end
    if (mUp && !mDown) begin
      nextY = incWrap(posYQ, YMax);
    end else if (mDown && !mUp) begin
      nextY = decWrap(posYQ, YMax);
    end
    moveIdx = cellIdx(nextX, nextY);
  end

  // Next-state logic: run control, moves, pellet collection and scoring.
  always_comb begin
    stateD   = stateQ;
    mapD     = mapQ;
    posXD    = posXQ;
    posYD    = posYQ;
    scoreD   = scoreQ;
    stepCntD = stepCntQ;
    pickupD  = 1'b0;
    unique case (stateQ)
      StIdle, StDone: begin
        if (start) begin
          stateD   = StRun;
          mapD     = InitMap;
          posXD    = StartX;
          posYD    = StartY;
          stepCntD = '0;
          scoreD   = '0;
          if (InitMap[StartIdx]) begin
            mapD[StartIdx] = 1'b0;
            scoreD         = ScoreOne;
            pickupD        = 1'b1;
          end
        end
      end
      StRun: begin
        if (step_en) begin
          posXD = nextX;
          posYD = nextY;
          if (mapQ[moveIdx]) begin
            mapD[moveIdx] = 1'b0;
            scoreD        = (scoreQ == ScoreMax) ? scoreQ : scoreQ + ScoreOne;
            pickupD       = 1'b1;
          end
          stepCntD = stepCntQ + StepOne;
          // The final move still lands on the same edge that ends the run.
          if (stepCntD == StepLimit) begin
            stateD = StDone;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ   <= StIdle;
      mapQ     <= InitMap;
      posXQ    <= StartX;
      posYQ    <= StartY;
      scoreQ   <= '0;
      stepCntQ <= '0;
      pickupQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      mapQ     <= mapD;
      posXQ    <= posXD;
      posYQ    <= posYD;
      scoreQ   <= scoreD;
      stepCntQ <= stepCntD;
      pickupQ  <= pickupD;
    end
  end

  assign lUp    = mapQ[cellIdx(posXQ, incWrap(posYQ, YMax))];
  assign lDown  = mapQ[cellIdx(posXQ, decWrap(posYQ, YMax))];
  assign lRight = mapQ[cellIdx(incWrap(posXQ, XMax), posYQ)];
  assign lLeft  = mapQ[cellIdx(decWrap(posXQ, XMax), posYQ)];

  assign pos_x  = posXQ;
  assign pos_y  = posYQ;
  assign score  = scoreQ;
  assign pickup = pickupQ;
  assign busy   = (stateQ == StRun);
  assign done   = (stateQ == StDone);

endmodule
